// File: rtl/gtech_fd_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gtech_fd_pipe                                                |
// | Description : WIDTH-bit, DEPTH-stage pipeline register with per-stage      |
// |               valid, global advance enable G, async clear CD, sync clear   |
// |               SCD, Q/QN outputs, selectable tap and an incrementally       |
// |               maintained occupancy count.                                  |
// |               Optional scan chain enabled by macro GTECH_FD_PIPE_SCAN_EN   |
// |               (adds TE/TI/TO).                                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module gtech_fd_pipe #(
  parameter int              WIDTH     = 8,
  parameter int              DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                                          CP,
  input  logic                                          CD,
  input  logic                                          SCD,
  input  logic                                          G,
  input  logic [WIDTH-1:0]                              D,
  input  logic                                          DV,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0]  SEL,
`ifdef GTECH_FD_PIPE_SCAN_EN
  input  logic                                          TE,
  input  logic                                          TI,
  output logic                                          TO,
`endif
  output logic [WIDTH-1:0]                              Q,
  output logic [WIDTH-1:0]                              QN,
  output logic                                          QV,
  output logic [WIDTH-1:0]                              TAP,
  output logic                                          TAPV,
  output logic [$clog2(DEPTH+1)-1:0]                    CNT
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DEPTH-1:0][WIDTH-1:0] c_clr = {DEPTH{RESET_VAL}};

  logic [DEPTH-1:0][WIDTH-1:0] r_stage;
  logic [DEPTH-1:0][WIDTH-1:0] w_shift;
  logic [DEPTH-1:0][WIDTH-1:0] w_stage_norm;
  logic [DEPTH-1:0][WIDTH-1:0] w_stage_nxt;
  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0]            w_vshift;
  logic [DEPTH-1:0]            w_valid_norm;
  logic [DEPTH-1:0]            w_valid_nxt;
  logic [CW-1:0]               r_cnt;
  logic [CW-1:0]               w_cnt_adv;
  logic [CW-1:0]               w_cnt_norm;
  logic [CW-1:0]               w_cnt_nxt;
  logic                        w_inc;
  logic                        w_dec;

  // Shifted view of the pipe: D/DV enter stage 0, the last stage drops out.
  generate
    if (DEPTH > 1) begin : g_multi
      assign w_shift  = {r_stage[DEPTH-2:0], D};
      assign w_vshift = {r_valid[DEPTH-2:0], DV};
    end else begin : g_single
      assign w_shift  = D;
      assign w_vshift = DV;
    end
  endgenerate

  // Occupancy changes only when a valid beat enters without one leaving, or vice versa.
  assign w_inc = DV & ~r_valid[DEPTH-1];
  assign w_dec = ~DV & r_valid[DEPTH-1];
  assign w_cnt_adv = w_inc ? (r_cnt + CW'(1)) : (w_dec ? (r_cnt - CW'(1)) : r_cnt);

  // Functional next state; ternaries (not if/else) so an X on SCD or G
  // propagates into the stages in simulation instead of being masked.
  always_comb begin
    w_stage_norm = (!SCD) ? c_clr : (G ? w_shift   : r_stage);
    w_valid_norm = (!SCD) ? '0    : (G ? w_vshift  : r_valid);
    w_cnt_norm   = (!SCD) ? '0    : (G ? w_cnt_adv : r_cnt);
  end

`ifdef GTECH_FD_PIPE_SCAN_EN
  localparam int NB = WIDTH * DEPTH;

  logic [NB-1:0]               w_flat;
  logic [NB-1:0]               w_scan_flat;
  logic [DEPTH-1:0][WIDTH-1:0] w_scan;

  // Chain order is stage0 bit0 first, so a left shift of the flattened pipe is one scan step.
  assign w_flat = r_stage;
  generate
    if (NB > 1) begin : g_scan_multi
      assign w_scan_flat = {w_flat[NB-2:0], TI};
    end else begin : g_scan_single
      assign w_scan_flat = TI;
    end
  endgenerate
  assign w_scan = w_scan_flat;
  assign TO     = w_flat[NB-1];

  // Scan overrides everything except CD; valids and count hold during scan.
  always_comb begin
    w_stage_nxt = TE ? w_scan  : w_stage_norm;
    w_valid_nxt = TE ? r_valid : w_valid_norm;
    w_cnt_nxt   = TE ? r_cnt   : w_cnt_norm;
  end
`else
  // Without scan the functional next state is used directly.
  always_comb begin
    w_stage_nxt = w_stage_norm;
    w_valid_nxt = w_valid_norm;
    w_cnt_nxt   = w_cnt_norm;
  end
`endif

  // State registers with asynchronous active-low clear.
  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      r_stage <= c_clr;
      r_valid <= '0;
      r_cnt   <= '0;
    end else begin
      r_stage <= w_stage_nxt;
      r_valid <= w_valid_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign Q   = r_stage[DEPTH-1];
  assign QN  = ~r_stage[DEPTH-1];
  assign QV  = r_valid[DEPTH-1];
  assign CNT = r_cnt;

  // Tap mux; out-of-range selects fall through to the clear value.
  always_comb begin
    TAP  = RESET_VAL;
    TAPV = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (SEL == SW'(i)) begin
        TAP  = r_stage[i];
        TAPV = r_valid[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gtech_fd_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_gtech_fd_pipe                                             |
// | Description : Scoreboard bench for gtech_fd_pipe (DEPTH=4 and DEPTH=5      |
// |               instances, plus a DEPTH=2 scan instance when                 |
// |               GTECH_FD_PIPE_SCAN_EN is defined).                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_gtech_fd_pipe;

  typedef struct {
    string      nm;
    int         kind;   // 0: main/tap checks, 1: scan checks
    logic [7:0] q;
    logic       qv;
    logic [2:0] cnt;
    logic [7:0] tap;
    logic       tapv;
    bit         chk5;
    logic [7:0] tap5;
    logic       tapv5;
    logic       to;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_assert = 0;
  int   n_fail   = 0;

  logic       clk = 1'b0;
  logic       cd, scd, g, dv;
  logic [7:0] d;
  logic [1:0] sel;
  logic [2:0] sel5;

  logic [7:0] q, qn, tap, q5, qn5, tap5;
  logic       qv, tapv, qv5, tapv5;
  logic [2:0] cnt, cnt5;

  always #5 clk = ~clk;

`ifdef GTECH_FD_PIPE_SCAN_EN
  logic       te0 = 1'b0, ti0 = 1'b0;
  logic       to_a, to_b;
  logic       s_te, s_ti, s_g, s_dv, s_scd, s_sel;
  logic [3:0] s_d, s_q, s_qn, s_tap;
  logic       s_qv, s_tapv, s_to;
  logic [1:0] s_cnt;
`endif

  gtech_fd_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) u_dut (
    .CP(clk), .CD(cd), .SCD(scd), .G(g), .D(d), .DV(dv), .SEL(sel),
`ifdef GTECH_FD_PIPE_SCAN_EN
    .TE(te0), .TI(ti0), .TO(to_a),
`endif
    .Q(q), .QN(qn), .QV(qv), .TAP(tap), .TAPV(tapv), .CNT(cnt)
  );

  gtech_fd_pipe #(.WIDTH(8), .DEPTH(5), .RESET_VAL(8'hA5)) u_dut5 (
    .CP(clk), .CD(cd), .SCD(scd), .G(g), .D(d), .DV(dv), .SEL(sel5),
`ifdef GTECH_FD_PIPE_SCAN_EN
    .TE(te0), .TI(ti0), .TO(to_b),
`endif
    .Q(q5), .QN(qn5), .QV(qv5), .TAP(tap5), .TAPV(tapv5), .CNT(cnt5)
  );

`ifdef GTECH_FD_PIPE_SCAN_EN
  gtech_fd_pipe #(.WIDTH(4), .DEPTH(2)) u_dut_scan (
    .CP(clk), .CD(cd), .SCD(s_scd), .G(s_g), .D(s_d), .DV(s_dv), .SEL(s_sel),
    .TE(s_te), .TI(s_ti), .TO(s_to),
    .Q(s_q), .QN(s_qn), .QV(s_qv), .TAP(s_tap), .TAPV(s_tapv), .CNT(s_cnt)
  );
`endif

  // Apply inputs (from negedge+1) and let one rising edge happen.
  task automatic drive(input logic gi, input logic scdi, input logic [7:0] di,
                       input logic dvi, input logic [1:0] si, input logic [2:0] s5i);
    g = gi; scd = scdi; d = di; dv = dvi; sel = si; sel5 = s5i;
    @(posedge clk); #1;
  endtask

  // Push the expected settled outputs, then move to the next negedge+1.
  task automatic chk(input string nm, input logic [7:0] eq, input logic eqv,
                     input logic [2:0] ec, input logic [7:0] et, input logic etv,
                     input bit c5 = 1'b0, input logic [7:0] et5 = 8'h00,
                     input logic etv5 = 1'b0);
    exp_t x;
    x.nm = nm; x.kind = 0; x.q = eq; x.qv = eqv; x.cnt = ec; x.tap = et;
    x.tapv = etv; x.chk5 = c5; x.tap5 = et5; x.tapv5 = etv5; x.to = 1'b0;
    sb.push_back(x);
    @(negedge clk); #1;
  endtask

  // Monitor: compare every pending expectation at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_assert++;
        if (e.kind == 0) begin
          if (!(q === e.q && qn === ~e.q && qv === e.qv && cnt === e.cnt &&
                tap === e.tap && tapv === e.tapv &&
                (!e.chk5 || (tap5 === e.tap5 && tapv5 === e.tapv5)))) begin
            n_fail++;
            $display("FAIL %s: got Q=%h QN=%h QV=%b CNT=%0d TAP=%h TAPV=%b TAP5=%h TAPV5=%b; want Q=%h QN=%h QV=%b CNT=%0d TAP=%h TAPV=%b TAP5=%h TAPV5=%b (tap5 checked=%0d)",
                     e.nm, q, qn, qv, cnt, tap, tapv, tap5, tapv5,
                     e.q, ~e.q, e.qv, e.cnt, e.tap, e.tapv, e.tap5, e.tapv5, e.chk5);
          end
        end else begin
`ifdef GTECH_FD_PIPE_SCAN_EN
          if (!(s_to === e.to && s_cnt === e.cnt[1:0] && s_qv === e.qv)) begin
            n_fail++;
            $display("FAIL %s: got TO=%b CNT=%0d QV=%b; want TO=%b CNT=%0d QV=%b",
                     e.nm, s_to, s_cnt, s_qv, e.to, e.cnt, e.qv);
          end
`endif
        end
      end
    end
  end

  // Watchdog against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want end of test");
    $fatal(1, "timeout");
  end

`ifdef GTECH_FD_PIPE_SCAN_EN
  task automatic sdrive(input logic tei, input logic tii, input logic gi,
                        input logic dvi, input logic scdi);
    s_te = tei; s_ti = tii; s_g = gi; s_dv = dvi; s_scd = scdi;
    @(posedge clk); #1;
  endtask

  task automatic schk(input string nm, input logic eto, input logic [2:0] ec,
                      input logic eqv);
    exp_t x;
    x.nm = nm; x.kind = 1; x.q = 8'h00; x.qv = eqv; x.cnt = ec; x.tap = 8'h00;
    x.tapv = 1'b0; x.chk5 = 1'b0; x.tap5 = 8'h00; x.tapv5 = 1'b0; x.to = eto;
    sb.push_back(x);
    @(negedge clk); #1;
  endtask
`endif

  // Directed stimulus with hand-computed expectations.
  initial begin
    logic [7:0] pat;
    cd = 1'b0; scd = 1'b1; g = 1'b0; d = 8'h00; dv = 1'b0; sel = 2'd0; sel5 = 3'd0;
`ifdef GTECH_FD_PIPE_SCAN_EN
    s_te = 1'b0; s_ti = 1'b0; s_g = 1'b0; s_dv = 1'b0; s_scd = 1'b1; s_sel = 1'b0;
    s_d = 4'hF;
`endif
    @(negedge clk); #1;
    chk("reset", 8'hA5, 1'b0, 3'd0, 8'hA5, 1'b0);
    cd = 1'b1;

    // Latency: first valid beat reaches Q after 4 advances.
    drive(1, 1, 8'h01, 1, 2'd0, 3'd0); chk("lat1", 8'hA5, 0, 3'd1, 8'h01, 1);
    drive(1, 1, 8'h02, 1, 2'd0, 3'd0); chk("lat2", 8'hA5, 0, 3'd2, 8'h02, 1);
    drive(1, 1, 8'h03, 1, 2'd0, 3'd0); chk("lat3", 8'hA5, 0, 3'd3, 8'h03, 1);
    drive(1, 1, 8'h04, 1, 2'd0, 3'd0); chk("lat4", 8'h01, 1, 3'd4, 8'h04, 1);
    drive(1, 1, 8'h05, 1, 2'd0, 3'd0); chk("lat5", 8'h02, 1, 3'd4, 8'h05, 1);

    // Hold with G=0 while D/DV toggle.
    drive(0, 1, 8'hAA, 0, 2'd1, 3'd0); chk("frz1", 8'h02, 1, 3'd4, 8'h04, 1);
    drive(0, 1, 8'h55, 1, 2'd1, 3'd0); chk("frz2", 8'h02, 1, 3'd4, 8'h04, 1);
    drive(0, 1, 8'hFF, 0, 2'd1, 3'd0); chk("frz3", 8'h02, 1, 3'd4, 8'h04, 1);

    // Drain with invalid beats: CNT 3,2,1,0; invalid data still shifts.
    drive(1, 1, 8'h10, 0, 2'd0, 3'd0); chk("drn1", 8'h03, 1, 3'd3, 8'h10, 0);
    drive(1, 1, 8'h11, 0, 2'd0, 3'd0); chk("drn2", 8'h04, 1, 3'd2, 8'h11, 0);
    drive(1, 1, 8'h12, 0, 2'd0, 3'd0); chk("drn3", 8'h05, 1, 3'd1, 8'h12, 0);
    drive(1, 1, 8'h13, 0, 2'd0, 3'd0); chk("drn4", 8'h10, 0, 3'd0, 8'h13, 0);

    // Alternating valids.
    drive(1, 1, 8'h21, 1, 2'd0, 3'd0); chk("alt1", 8'h11, 0, 3'd1, 8'h21, 1);
    drive(1, 1, 8'h22, 0, 2'd0, 3'd0); chk("alt2", 8'h12, 0, 3'd1, 8'h22, 0);
    drive(1, 1, 8'h23, 1, 2'd0, 3'd0); chk("alt3", 8'h13, 0, 3'd2, 8'h23, 1);
    drive(1, 1, 8'h24, 0, 2'd0, 3'd0); chk("alt4", 8'h21, 1, 3'd2, 8'h24, 0);

    // Tap sweep (held pipe); DEPTH=5 instance checked at SEL=7, 3 and 4.
    drive(0, 1, 8'h00, 0, 2'd0, 3'd7); chk("sel0", 8'h21, 1, 3'd2, 8'h24, 0, 1, 8'hA5, 0);
    drive(0, 1, 8'h00, 0, 2'd1, 3'd7); chk("sel1", 8'h21, 1, 3'd2, 8'h23, 1, 1, 8'hA5, 0);
    drive(0, 1, 8'h00, 0, 2'd2, 3'd7); chk("sel2", 8'h21, 1, 3'd2, 8'h22, 0, 1, 8'hA5, 0);
    drive(0, 1, 8'h00, 0, 2'd3, 3'd7); chk("sel3", 8'h21, 1, 3'd2, 8'h21, 1, 1, 8'hA5, 0);
    drive(0, 1, 8'h00, 0, 2'd3, 3'd3); chk("sel5_3", 8'h21, 1, 3'd2, 8'h21, 1, 1, 8'h21, 1);
    drive(0, 1, 8'h00, 0, 2'd3, 3'd4); chk("sel5_4", 8'h21, 1, 3'd2, 8'h21, 1, 1, 8'h13, 0);

    // Refill, then synchronous clear wins over G.
    drive(1, 1, 8'h31, 1, 2'd0, 3'd0); chk("fil1", 8'h22, 0, 3'd2, 8'h31, 1);
    drive(1, 1, 8'h32, 1, 2'd0, 3'd0); chk("fil2", 8'h23, 1, 3'd3, 8'h32, 1);
    drive(1, 1, 8'h33, 1, 2'd0, 3'd0); chk("fil3", 8'h24, 0, 3'd3, 8'h33, 1);
    drive(1, 1, 8'h34, 1, 2'd0, 3'd0); chk("fil4", 8'h31, 1, 3'd4, 8'h34, 1);
    drive(1, 0, 8'h77, 1, 2'd0, 3'd0); chk("scd", 8'hA5, 0, 3'd0, 8'hA5, 0);
    drive(1, 1, 8'h41, 1, 2'd0, 3'd0); chk("post_scd", 8'hA5, 0, 3'd1, 8'h41, 1);

    // Asynchronous clear mid-cycle, then a normal edge after release.
    drive(1, 1, 8'h42, 1, 2'd0, 3'd0);
    #1; cd = 1'b0; g = 1'b0; d = 8'h43;
    chk("cd_async", 8'hA5, 0, 3'd0, 8'hA5, 0);
    cd = 1'b1;
    drive(1, 1, 8'h44, 1, 2'd0, 3'd0); chk("cd_rel", 8'hA5, 0, 3'd1, 8'h44, 1);
    drive(0, 1, 8'h45, 0, 2'd0, 3'd0);

`ifdef GTECH_FD_PIPE_SCAN_EN
    // Scan: load two valid beats, scan a byte in (G/SCD active but overridden), read it out.
    pat = 8'b1011_0010;
    sdrive(0, 0, 1, 1, 1);
    sdrive(0, 0, 1, 1, 1);
    for (int k = 0; k < 8; k++) sdrive(1, pat[7-k], 1, 0, 0);
    for (int k = 0; k < 8; k++) begin
      schk($sformatf("scan_out%0d", k), pat[7-k], 3'd2, 1'b1);
      sdrive(1, 0, 1, 0, 0);
    end
    s_te = 1'b0; s_scd = 1'b1; s_g = 1'b0;
`else
    pat = 8'h00;
`endif

    // Let the monitor drain the scoreboard, with a bounded wait.
    for (int w = 0; w < 4 && sb.size() > 0; w++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
